// File: rtl/psum_drain_pkg.sv
// Shared types and constants for the psum drain block: FSM state encoding
// and the partial-sum width rule (psum = 2 x activation/weight width).
package psum_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int PSUM_MULT      = 2;
    localparam int DATA_WIDTH_DEF = 24;
    localparam int PSUM_WIDTH_DEF = PSUM_MULT * DATA_WIDTH_DEF;
    localparam int VEC_TOTAL_W    = 16;

    function automatic int psum_width(input int data_width);
        return PSUM_MULT * data_width;
    endfunction

endpackage

// File: rtl/psum_drain_fifo.sv
// Synchronous FIFO for aligned psum vectors; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module psum_drain_fifo
    import psum_drain_pkg::*;
#(
    parameter int WIDTH = PSUM_WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_en;
    logic             pop_en;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage carries no reset; only pointers and occupancy define
    // what is valid, so resetting the array would just cost area and fanout.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Drains the bottom PE row: deskews the staggered column psums into aligned
// vectors, buffers them, and hands them out over a valid/ready port.
// Optional macro PSUM_DRAIN_RELU_EN clamps negative output columns to zero.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int data_width         = DATA_WIDTH_DEF,
    parameter int w_tile_column_size = 6,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic [VEC_TOTAL_W-1:0]                       vec_total,
    input  logic                                         in_valid,
    input  logic [2*data_width*w_tile_column_size-1:0]   in_sum,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [2*data_width*w_tile_column_size-1:0]   out_data,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         overflow
);

    localparam int PW   = psum_width(data_width);
    localparam int COLS = w_tile_column_size;
    localparam int VW   = PW * COLS;
    localparam int LAT  = COLS - 1;

    state_t                 state;
    logic [VEC_TOTAL_W-1:0] vec_total_q;
    logic [VEC_TOTAL_W-1:0] entered_cnt;
    logic [VEC_TOTAL_W-1:0] aligned_cnt;
    logic [LAT-1:0]         vld_sr;
    logic [VW-1:0]          aligned_vec;
    logic                   aligned_valid;
    logic                   accept;
    logic                   drop;
    logic [VW-1:0]          fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Stop accepting once the whole job has entered the delay line.
    assign accept        = (state == ST_ACTIVE) && in_valid && (entered_cnt < vec_total_q);
    assign aligned_valid = vld_sr[LAT-1];
    assign drop          = aligned_valid && fifo_full && !out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= accept;
            for (int k = 1; k < LAT; k++) begin
                vld_sr[k] <= vld_sr[k-1];
            end
        end
    end

    // Column c arrives c cycles after column 0, so it waits LAT-c cycles.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = LAT - c;
        if (D == 0) begin : g_pass
            assign aligned_vec[c*PW +: PW] = in_sum[c*PW +: PW];
        end else begin : g_dly
            logic [PW-1:0] sr [D];
            always_ff @(posedge clk) begin
                sr[0] <= in_sum[c*PW +: PW];
                for (int k = 1; k < D; k++) begin
                    sr[k] <= sr[k-1];
                end
            end
            assign aligned_vec[c*PW +: PW] = sr[D-1];
        end
    end

    psum_drain_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aligned_valid),
        .pop   (out_ready),
        .wdata (aligned_vec),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;

`ifdef PSUM_DRAIN_RELU_EN
    // NOTE: every always_comb target gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        out_data = '0;
        if (!fifo_empty) begin
            for (int c = 0; c < COLS; c++) begin
                out_data[c*PW +: PW] = fifo_rdata[c*PW + PW - 1] ? '0 : fifo_rdata[c*PW +: PW];
            end
        end
    end
`else
    assign out_data = fifo_empty ? '0 : fifo_rdata;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            vec_total_q <= '0;
            entered_cnt <= '0;
            aligned_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                entered_cnt <= entered_cnt + 1'b1;
            end
            if (aligned_valid) begin
                aligned_cnt <= aligned_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec_total_q <= vec_total;
                        entered_cnt <= '0;
                        aligned_cnt <= '0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        if (vec_total == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (aligned_valid && (aligned_cnt + 1'b1 == vec_total_q)) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty && !(|vld_sr)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: skewed column stimulus, expected
// vectors queued at issue time and compared on each output handshake.
module tb_psum_drain;

    localparam int DW    = 24;
    localparam int COLS  = 6;
    localparam int DEPTH = 4;
    localparam int PW    = 2 * DW;
    localparam int VW    = PW * COLS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   vec_total = '0;
    logic          in_valid = 1'b0;
    logic [VW-1:0] in_sum = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          overflow;

    psum_drain #(
        .data_width         (DW),
        .w_tile_column_size (COLS),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_total (vec_total),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            first_ov = -1;
    int            last_done_cyc = -1;
    int            pop_cyc [$];
    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] last_pop_data = '0;
    logic [VW-1:0] hist_vec [COLS];
    bit            hist_v [COLS];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every handshake pops one expected vector.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected got %0h want no vector", out_data);
                end else begin
                    logic [VW-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL pop_data got %0h want %0h", out_data, e);
                    end
                end
                last_pop_data = out_data;
                pop_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [VW-1:0] make_vec(input int base);
        logic [VW-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*PW +: PW] = PW'(base + c + 1);
        return v;
    endfunction

    function automatic logic [VW-1:0] model(input logic [VW-1:0] v);
        logic [VW-1:0] m;
        m = v;
`ifdef PSUM_DRAIN_RELU_EN
        for (int c = 0; c < COLS; c++) if (v[c*PW + PW - 1]) m[c*PW +: PW] = '0;
`endif
        return m;
    endfunction

    // One cycle: column c of in_sum carries the vector issued c cycles ago.
    task automatic tick(input bit v, input logic [VW-1:0] vec);
        for (int k = COLS - 1; k > 0; k--) begin
            hist_vec[k] = hist_vec[k-1];
            hist_v[k]   = hist_v[k-1];
        end
        hist_vec[0] = vec;
        hist_v[0]   = v;
        in_valid    = v;
        for (int c = 0; c < COLS; c++) begin
            if (hist_v[c]) in_sum[c*PW +: PW] = hist_vec[c][c*PW +: PW];
            else           in_sum[c*PW +: PW] = PW'({$urandom(), $urandom()});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0);
    endtask

    task automatic wait_done(input int budget, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1'b0, '0);
            if (done_cnt > base) ok = 1'b1;
        end
    endtask

    task automatic open_job(input int n);
        start     = 1'b1;
        vec_total = 16'(n);
        tick(1'b0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_single();
        int base, t0;
        bit ok;
        logic [VW-1:0] v, want;
        exp_q.delete(); pop_cyc.delete();
        base = done_cnt;
        out_ready = 1'b1;
        open_job(1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        idle(2);
        for (int c = 0; c < COLS; c++) want[c*PW +: PW] = PW'(c + 1);
        v = make_vec(0);
        exp_q.push_back(model(v));
        first_ov = -1;
        t0 = cyc;
        tick(1'b1, v);
        wait_done(40, base, ok);
        checks += 6;
        if (!ok) begin errors++; $display("FAIL single_done_timeout got none want done"); end
        if (first_ov != t0 + 6) begin errors++; $display("FAIL single_latency got %0d want %0d", first_ov, t0 + 6); end
        if (pop_cyc.size() != 1) begin errors++; $display("FAIL single_pops got %0d want 1", pop_cyc.size()); end
        if (last_pop_data !== want) begin errors++; $display("FAIL single_data got %0h want %0h", last_pop_data, want); end
        if (pop_cyc.size() > 0 && last_done_cyc <= pop_cyc[0]) begin
            errors++; $display("FAIL single_done_order got %0d want after %0d", last_done_cyc, pop_cyc[0]);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok, gap;
        logic [VW-1:0] v;
        exp_q.delete(); pop_cyc.delete();
        base = done_cnt;
        out_ready = 1'b1;
        open_job(8);
        for (int k = 0; k < 10; k++) begin
            v = make_vec(16 * k + 7);
            if (k < 8) exp_q.push_back(model(v));
            tick(1'b1, v);
        end
        wait_done(60, base, ok);
        idle(5);
        gap = 1'b0;
        for (int k = 1; k < pop_cyc.size(); k++) if (pop_cyc[k] != pop_cyc[k-1] + 1) gap = 1'b1;
        checks += 5;
        if (!ok) begin errors++; $display("FAIL b2b_done_timeout got none want done"); end
        if (pop_cyc.size() != 8) begin errors++; $display("FAIL b2b_pops got %0d want 8", pop_cyc.size()); end
        if (gap) begin errors++; $display("FAIL b2b_gap got gap want one per cycle"); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
        if (done_cnt - base != 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - base); end
    endtask

    task automatic test_overflow();
        int base;
        bit ok;
        logic [VW-1:0] v;
        exp_q.delete(); pop_cyc.delete();
        base = done_cnt;
        out_ready = 1'b0;
        open_job(6);
        for (int k = 0; k < 6; k++) begin
            v = make_vec(1000 * (k + 1));
            if (k < DEPTH) exp_q.push_back(model(v));
            tick(1'b1, v);
        end
        idle(10);
        checks += 5;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_out_valid got %b want 1", out_valid); end
        if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b want 1", busy); end
        if (done_cnt != base) begin errors++; $display("FAIL ovf_early_done got %0d want %0d", done_cnt, base); end
        if (out_data !== exp_q[0]) begin errors++; $display("FAIL ovf_hold1 got %0h want %0h", out_data, exp_q[0]); end
        idle(3);
        checks++;
        if (out_data !== exp_q[0]) begin errors++; $display("FAIL ovf_hold2 got %0h want %0h", out_data, exp_q[0]); end
        out_ready = 1'b1;
        wait_done(40, base, ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL ovf_done_timeout got none want done"); end
        if (pop_cyc.size() != DEPTH) begin errors++; $display("FAIL ovf_pops got %0d want %0d", pop_cyc.size(), DEPTH); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_left got %0d want 0", exp_q.size()); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_relu();
        int base;
        bit ok;
        logic [VW-1:0] v;
        logic signed [PW-1:0] neg5, want2;
        neg5 = -5;
`ifdef PSUM_DRAIN_RELU_EN
        want2 = '0;
`else
        want2 = neg5;
`endif
        exp_q.delete(); pop_cyc.delete();
        base = done_cnt;
        out_ready = 1'b1;
        open_job(1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL relu_ovf_clear got %b want 0", overflow); end
        v = make_vec(100);
        v[2*PW +: PW] = neg5;
        exp_q.push_back(model(v));
        tick(1'b1, v);
        wait_done(40, base, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL relu_done_timeout got none want done"); end
        if (last_pop_data[2*PW +: PW] !== want2) begin
            errors++; $display("FAIL relu_col2 got %0h want %0h", last_pop_data[2*PW +: PW], want2);
        end
        if (last_pop_data[0 +: PW] !== PW'(101)) begin
            errors++; $display("FAIL relu_col0 got %0h want %0h", last_pop_data[0 +: PW], PW'(101));
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        logic [VW-1:0] v;
        exp_q.delete(); pop_cyc.delete();
        out_ready = 1'b0;
        open_job(5);
        tick(1'b1, make_vec(300));
        tick(1'b1, make_vec(400));
        idle(8);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_buffered got %b want 1", out_valid); end
        base = done_cnt;
        rst_n = 1'b0;
        tick(1'b0, '0);
        rst_n = 1'b1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        idle(10);
        checks++;
        if (done_cnt != base) begin errors++; $display("FAIL rst_mid_done got %0d want %0d", done_cnt, base); end
        pop_cyc.delete();
        out_ready = 1'b1;
        open_job(2);
        for (int k = 0; k < 2; k++) begin
            v = make_vec(500 + 10 * k);
            exp_q.push_back(model(v));
            tick(1'b1, v);
        end
        wait_done(40, base, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rst_mid_rerun_timeout got none want done"); end
        if (pop_cyc.size() != 2) begin errors++; $display("FAIL rst_mid_rerun_pops got %0d want 2", pop_cyc.size()); end
    endtask

    task automatic test_zero_and_ignore();
        int base;
        bit ok;
        logic [VW-1:0] v;
        exp_q.delete(); pop_cyc.delete();
        base = done_cnt;
        open_job(0);
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
        if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b want 1", busy); end
        idle(1);
        checks += 3;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_len got %b want 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_idle got %b want 0", busy); end
        if (done_cnt - base != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_cnt - base); end
        base = done_cnt;
        out_ready = 1'b1;
        open_job(2);
        open_job(7);
        for (int k = 0; k < 3; k++) begin
            v = make_vec(700 + 10 * k);
            if (k < 2) exp_q.push_back(model(v));
            tick(1'b1, v);
        end
        wait_done(40, base, ok);
        idle(4);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL ignore_done_timeout got none want done"); end
        if (pop_cyc.size() != 2) begin errors++; $display("FAIL ignore_pops got %0d want 2", pop_cyc.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy got %b want 0", busy); end
    endtask

    initial begin
        for (int k = 0; k < COLS; k++) begin
            hist_vec[k] = '0;
            hist_v[k]   = 1'b0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_relu();
        test_reset_mid();
        test_zero_and_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
